conv_maxpool_stream: RTL and testbench



---
 rtl/conv_pkg.sv | 15 +
 rtl/pool_idx_counter.sv | 41 ++++
 rtl/conv_maxpool_stream.sv | 69 ++++++
 tb/tb_conv_maxpool_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Types, vector geometry and a signed-max helper for the conv output stream
// and its pooling stages.
package conv_pkg;
    localparam int SAMPLE_W     = 16;
    localparam int LENX         = 64;
    localparam int LENF         = 33;
    localparam int LENY         = LENX - LENF + 1;
    localparam int POOL_DEFAULT = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (b > a) ? b : a;
    endfunction
endpackage

// File: rtl/pool_idx_counter.sv
// Window and vector position counters for the pooling stage; both advance
// once per accepted sample and hold otherwise, and both clear on the vector wrap.
module pool_idx_counter #(
    parameter int POOL   = 2,
    parameter int LENY   = 32,
    parameter int LOGLEN = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic win_first,
    output logic win_last,
    output logic vec_last
);
    logic [LOGLEN-1:0] win_cnt_q, win_cnt_d;
    logic [LOGLEN-1:0] vec_cnt_q, vec_cnt_d;

    assign win_first = (win_cnt_q == '0);
    assign win_last  = (win_cnt_q == LOGLEN'(POOL - 1));
    assign vec_last  = (vec_cnt_q == LOGLEN'(LENY - 1));

    always_comb begin
        win_cnt_d = win_cnt_q;
        vec_cnt_d = vec_cnt_q;
        if (advance) begin
            vec_cnt_d = vec_last ? '0 : vec_cnt_q + LOGLEN'(1);
            // A vector end forces a fresh window even if it is short.
            win_cnt_d = (win_last || vec_last) ? '0 : win_cnt_q + LOGLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q <= '0;
            vec_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            vec_cnt_q <= vec_cnt_d;
        end
    end
endmodule

// File: rtl/conv_maxpool_stream.sv
// Streaming 1-D max-pool over the conv y stream, one z per POOL samples (short
// final window per vector flushed); z is registered one cycle after its last sample; a stalled z blocks y.
module conv_maxpool_stream
    import conv_pkg::*;
#(
    parameter int WIDTH  = conv_pkg::SAMPLE_W,
    parameter int POOL   = conv_pkg::POOL_DEFAULT,
    parameter int LENY   = conv_pkg::LENY,
    parameter int LOGLEN = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z
);
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic signed [WIDTH-1:0] cand;
    logic                    accept, complete;
    logic                    win_first, win_last, vec_last;

    assign s_ready_y    = !reset && (!m_valid_q || m_ready_z);
    assign accept       = s_valid_y && s_ready_y;
    assign m_data_out_z = m_data_q;
    assign m_valid_z    = m_valid_q;

    pool_idx_counter #(
        .POOL   (POOL),
        .LENY   (LENY),
        .LOGLEN (LOGLEN)
    ) u_idx (
        .clk       (clk),
        .reset     (reset),
        .advance   (accept),
        .win_first (win_first),
        .win_last  (win_last),
        .vec_last  (vec_last)
    );

    always_comb begin
        cand      = (win_first || (s_data_in_y > acc_q)) ? s_data_in_y : acc_q;
        complete  = accept && (win_last || vec_last);
        acc_d     = accept ? cand : acc_q;
        m_data_d  = complete ? cand : m_data_q;
        m_valid_d = m_valid_q;
        if (m_valid_q && m_ready_z)
            m_valid_d = 1'b0;
        // A completion in the transfer cycle reloads with no bubble.
        if (complete)
            m_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end
endmodule

// File: tb/tb_conv_maxpool_stream.sv
// Directed and randomized checks of conv_maxpool_stream: a LENY=32 instance and
// a LENY=5 instance share the input stimulus; sel picks which outputs are observed.
module tb_conv_maxpool_stream;
    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               m_ready;
    logic               sel;

    logic               rdy32, vld32, rdy5, vld5;
    logic signed [15:0] dat32, dat5;
    logic               rdy_sel, vld_sel;
    logic signed [15:0] dat_sel;

    int                 errors = 0;
    int                 checks = 0;
    int                 rdy_low = 0;
    logic signed [15:0] zq[$];
    logic signed [15:0] samp[9984];
    logic signed [15:0] expq[$];
    bit                 drv_done;

    always #5 clk = ~clk;

    conv_maxpool_stream #(.WIDTH(16), .POOL(2), .LENY(32), .LOGLEN(6)) u_dut32 (
        .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
        .s_ready_y(rdy32), .m_data_out_z(dat32), .m_valid_z(vld32), .m_ready_z(m_ready)
    );

    conv_maxpool_stream #(.WIDTH(16), .POOL(2), .LENY(5), .LOGLEN(3)) u_dut5 (
        .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
        .s_ready_y(rdy5), .m_data_out_z(dat5), .m_valid_z(vld5), .m_ready_z(m_ready)
    );

    assign rdy_sel = sel ? rdy5 : rdy32;
    assign vld_sel = sel ? vld5 : vld32;
    assign dat_sel = sel ? dat5 : dat32;

    // Output collector: a transfer is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (!reset && vld_sel && m_ready) zq.push_back(dat_sel);
        if (!reset && !rdy_sel) rdy_low++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] qget(input int i);
        if (i < zq.size()) return 32'(zq[i]);
        return 32'sh7fff_0bad;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic signed [15:0] v);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = v;
        forever begin
            @(negedge clk);
            if (rdy_sel === 1'b1) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $error("FAIL send_timeout: observed no s_ready_y expected acceptance of %0d", v);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        zq.delete();
        rdy_low = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int mism;
        logic signed [15:0] a, b;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        sel     = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_s_ready", rdy_sel, 0);
        check("rst_m_valid", vld_sel, 0);
        check("rst_m_data", dat_sel, 0);

        // Basic pairs, ready always high
        do_reset();
        send(16'sd5);
        check("t1_no_z_first", vld_sel, 0);
        send(-16'sd3);
        check("t1_lat_valid", vld_sel, 1);
        check("t1_lat_data", dat_sel, 5);
        send(16'sd7);
        send(16'sd7);
        check("t1_tie_data", dat_sel, 7);
        send(-16'sd8);
        send(-16'sd2);
        check("t1_neg_data", dat_sel, -2);
        drain(3);
        check("t1_count", zq.size(), 3);
        check("t1_z0", qget(0), 5);
        check("t1_z1", qget(1), 7);
        check("t1_z2", qget(2), -2);
        check("t1_ready_high", rdy_low, 0);

        // Short vector (LENY=5): one-sample flush then a fresh window
        sel = 1'b1;
        do_reset();
        send(16'sd1);
        send(16'sd9);
        send(16'sd4);
        send(16'sd2);
        send(16'sd6);
        check("t2_flush_valid", vld_sel, 1);
        check("t2_flush_data", dat_sel, 6);
        send(16'sd3);
        send(16'sd8);
        drain(3);
        check("t2_count", zq.size(), 4);
        check("t2_z0", qget(0), 9);
        check("t2_z1", qget(1), 4);
        check("t2_z2", qget(2), 6);
        check("t2_z3", qget(3), 8);

        // Backpressure: z held, y blocked
        sel = 1'b0;
        do_reset();
        m_ready = 1'b0;
        send(16'sd100);
        send(-16'sd50);
        s_valid = 1'b1;
        s_data  = 16'sd3;
        begin
            int bad_rdy, bad_dat;
            bad_rdy = 0;
            bad_dat = 0;
            repeat (10) begin
                @(negedge clk);
                if (rdy_sel !== 1'b0) bad_rdy++;
                if (vld_sel !== 1'b1 || dat_sel !== 16'sd100) bad_dat++;
            end
            check("t3_ready_low_cycles", bad_rdy, 0);
            check("t3_hold_cycles", bad_dat, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(16'sd3);
        send(16'sd4);
        drain(3);
        check("t3_count", zq.size(), 2);
        check("t3_z0", qget(0), 100);
        check("t3_z1", qget(1), 4);

        // Full vector with extremes
        do_reset();
        for (int i = 0; i < 32; i++) send((i == 17) ? 16'sh7fff : 16'sh8000);
        drain(3);
        check("t4_count", zq.size(), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t4_z%0d", i), qget(i), (i == 8) ? 32767 : -32768);

        // Reset mid-window discards the partial window
        do_reset();
        send(16'sd50);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", rdy_sel, 0);
        @(posedge clk);
        #1;
        check("t5_rst_valid", vld_sel, 0);
        reset = 1'b0;
        send(-16'sd1);
        send(-16'sd2);
        drain(3);
        check("t5_count", zq.size(), 1);
        check("t5_z0", qget(0), -1);
        check("t5_valid_idle", vld_sel, 0);

        // Random valid/ready over 312 vectors against a reference model
        do_reset();
        for (int i = 0; i < 9984; i++) samp[i] = 16'($urandom);
        expq.delete();
        for (int i = 0; i < 9984; i += 2) begin
            a = samp[i];
            b = samp[i+1];
            expq.push_back((b > a) ? b : a);
        end
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 9984; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(samp[i]);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        drain(5);
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (i >= zq.size() || zq[i] !== expq[i]) mism++;
        check("t6_count", zq.size(), 4992);
        check("t6_mismatches", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
